fifolanerd: RTL and testbench

FIFOLANERD -- requirements
Module: fifolanerd

---
 rtl/fifolanerd_if.sv | 25 ++
 rtl/fifolanerd.sv | 82 ++++++++
 tb/tb_fifolanerd.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fifolanerd_if.sv
// rtl/fifolanerd_if.sv - upstream word FIFO and downstream lane handshake bundle
interface fifolanerd_if #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
);
    logic               fifordy;
    logic [WIDTH-1:0]   fifodout;
    logic               fifoget;
    logic [2*WIDTH-1:0] lane;
    logic               lanevld;
    logic               laneget;
    logic               blkend;
    logic [CNTW-1:0]    lanecnt;
    logic               rderr;

    modport master (
        input  fifordy, fifodout, laneget,
        output fifoget, lane, lanevld, blkend, lanecnt, rderr
    );

    modport slave (
        output fifordy, fifodout, laneget,
        input  fifoget, lane, lanevld, blkend, lanecnt, rderr
    );
endinterface

// File: rtl/fifolanerd.sv
// rtl/fifolanerd.sv - pairs upstream FIFO words into 2*WIDTH lanes, counted per absorb block
module fifolanerd #(
    parameter int WIDTH = 32,
    parameter int LANES = 17,
    parameter int CNTW  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    fifolanerd_if.master  bus
);
    typedef enum logic [1:0] {WLO, WHI, OUT} state_t;

    localparam logic [CNTW-1:0] LAST = CNTW'(LANES - 1);

    state_t             state;
    logic [2*WIDTH-1:0] lane_q;
    logic               vld_q;
    logic [CNTW-1:0]    cnt_q;
    logic               err_q;
    logic               xfer;

    // Accepting the held lane frees the low half in the same cycle.
    assign xfer = bus.fifordy & ~rst & ~flush &
                  ((state == WLO) | (state == WHI) | ((state == OUT) & bus.laneget));

    assign bus.fifoget = xfer;
    assign bus.lane    = lane_q;
    assign bus.lanevld = vld_q;
    assign bus.lanecnt = cnt_q;
    assign bus.blkend  = vld_q & (cnt_q == LAST);
    assign bus.rderr   = err_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= WLO;
            lane_q <= '0;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else if (flush) begin
            // lane bits are kept; a partial low word is simply forgotten
            state <= WLO;
            vld_q <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= bus.laneget & ~vld_q;
            case (state)
                WLO: begin
                    if (xfer) begin
                        lane_q[WIDTH-1:0] <= bus.fifodout;
                        state             <= WHI;
                    end
                end
                WHI: begin
                    if (xfer) begin
                        lane_q[2*WIDTH-1:WIDTH] <= bus.fifodout;
                        vld_q                   <= 1'b1;
                        state                   <= OUT;
                    end
                end
                OUT: begin
                    if (bus.laneget) begin
                        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                        vld_q <= 1'b0;
                        if (xfer) begin
                            lane_q[WIDTH-1:0] <= bus.fifodout;
                            state             <= WHI;
                        end else begin
                            state <= WLO;
                        end
                    end
                end
                default: begin
                    state <= WLO;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifolanerd.sv
// tb/tb_fifolanerd.sv - randomized and directed bench against a word-count lane model
module tb_fifolanerd;
    localparam int WIDTH = 32;
    localparam int LANES = 17;
    localparam int CNTW  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    fifolanerd_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    fifolanerd #(.WIDTH(WIDTH), .LANES(LANES), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: words currently held toward the lane (0, 1, or 2 = complete lane).
    logic [WIDTH-1:0]   q[$];
    int                 m_held = 0;
    logic [2*WIDTH-1:0] m_lane = '0;
    int                 m_cnt  = 0;
    bit                 m_err  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic rdy, input logic lg);
        logic             exp_get;
        logic [WIDTH-1:0] w;
        @(posedge clk);
        #1;
        rst         = r;
        flush       = f;
        bus.laneget = lg;
        if (rdy && q.size() > 0) begin
            bus.fifordy  = 1'b1;
            bus.fifodout = q[0];
        end else begin
            bus.fifordy  = 1'b0;
            bus.fifodout = $urandom;
        end
        @(negedge clk);
        exp_get = bus.fifordy && !r && !f && (m_held != 2 || lg);
        chk("fifoget", 64'(bus.fifoget), 64'(exp_get));
        chk("lanevld", 64'(bus.lanevld), 64'(m_held == 2));
        chk("lane",    64'(bus.lane),    64'(m_lane));
        chk("lanecnt", 64'(bus.lanecnt), 64'(m_cnt));
        chk("blkend",  64'(bus.blkend),  64'(m_held == 2 && m_cnt == LANES - 1));
        chk("rderr",   64'(bus.rderr),   64'(m_err && !r));
        w = '0;
        if (exp_get) w = q.pop_front();
        if (r) begin
            m_held = 0; m_lane = '0; m_cnt = 0; m_err = 1'b0;
        end else if (f) begin
            m_held = 0; m_cnt = 0; m_err = 1'b0;
        end else begin
            m_err = lg && (m_held != 2);
            if (m_held == 2 && lg) begin
                m_cnt  = (m_cnt + 1) % LANES;
                m_held = 0;
            end
            if (exp_get) begin
                if (m_held == 0) m_lane[WIDTH-1:0] = w;
                else             m_lane[2*WIDTH-1:WIDTH] = w;
                m_held = m_held + 1;
            end
        end
    endtask

    initial begin
        int lanes_seen;
        int blk_seen;
        int blk_idx;
        logic [2*WIDTH-1:0] held_lane;

        bus.fifordy  = 1'b0;
        bus.fifodout = '0;
        bus.laneget  = 1'b0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_lane", 64'(bus.lane), 64'h0);

        // single lane
        step(0, 0, 0, 0);
        q.push_back(32'h11111111);
        q.push_back(32'h22222222);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("r35_lane", bus.lane, 64'h2222222211111111);
        chk("r35_vld", 64'(bus.lanevld), 64'h1);
        chk("r35_cnt0", 64'(bus.lanecnt), 64'h0);
        step(0, 0, 1, 1);
        chk("r35_vld_drop", 64'(bus.lanevld), 64'h0);
        chk("r35_cnt1", 64'(bus.lanecnt), 64'h1);

        // one full absorb block
        step(1, 0, 0, 0);
        for (int i = 0; i < 34; i++) q.push_back(32'h5A000000 + i);
        lanes_seen = 0; blk_seen = 0; blk_idx = -1;
        for (int i = 0; i < 150 && lanes_seen < 17; i++) begin
            step(0, 0, 1, 1);
            if (bus.lanevld) begin
                if (bus.blkend) begin blk_seen++; blk_idx = lanes_seen; end
                lanes_seen++;
            end
        end
        step(0, 0, 1, 1);
        chk("r36_lanes", 64'(lanes_seen), 64'd17);
        chk("r36_blkend_n", 64'(blk_seen), 64'd1);
        chk("r36_blkend_idx", 64'(blk_idx), 64'd16);
        chk("r36_wrap", 64'(bus.lanecnt), 64'h0);

        // downstream stall
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) q.push_back($urandom);
        for (int i = 0; i < 10 && !bus.lanevld; i++) step(0, 0, 1, 0);
        held_lane = bus.lane;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0);
            chk("r37_stall_get", 64'(bus.fifoget), 64'h0);
            chk("r37_stable", bus.lane, held_lane);
        end
        for (int i = 0; i < 30 && (q.size() > 0 || m_held != 0); i++) step(0, 0, 1, 1);
        chk("r37_drained", 64'(q.size()), 64'h0);

        // flush discards a captured low word
        step(1, 0, 0, 0);
        q.push_back(32'hAAAAAAAA);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        q.push_back(32'h00000001);
        q.push_back(32'h00000002);
        for (int i = 0; i < 10 && !bus.lanevld; i++) step(0, 0, 1, 0);
        chk("r38_lane", bus.lane, 64'h0000000200000001);
        chk("r38_cnt", 64'(bus.lanecnt), 64'h0);

        // laneget with no lane held
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("r39_err", 64'(bus.rderr), 64'h1);
        chk("r39_cnt", 64'(bus.lanecnt), 64'h0);
        step(0, 0, 0, 0);
        chk("r39_err_pulse", 64'(bus.rderr), 64'h0);

        // reset while a lane is held
        step(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) q.push_back($urandom);
        for (int i = 0; i < 60 && !(bus.lanevld && bus.lanecnt == 9); i++) step(0, 0, 1, 1);
        chk("r40_reached", 64'(bus.lanevld && bus.lanecnt == 9), 64'h1);
        step(1, 0, 1, 1);
        chk("r40_get_rst", 64'(bus.fifoget), 64'h0);
        step(0, 0, 0, 0);
        chk("r40_vld", 64'(bus.lanevld), 64'h0);
        chk("r40_cnt", 64'(bus.lanecnt), 64'h0);
        chk("r40_lane", bus.lane, 64'h0);
        q.delete();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (q.size() < 4) q.push_back($urandom);
            step(($urandom % 200) == 0, ($urandom % 50) == 0,
                 ($urandom % 4) != 0, ($urandom % 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
